// File: rtl/ub_read_streamer.sv
// rtl/ub_read_streamer.sv - unified buffer read initiator: burst splitting, credit-based issue, FWFT return FIFO
// Optional WAIT-state watchdog is enabled by defining UB_RD_TIMEOUT_EN.
module ub_read_streamer #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 7,
  parameter int FIFO_DEPTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH:0]   cmd_addr_i,
  input  logic [ADDR_WIDTH+1:0] cmd_len_i,
  output logic                  ub_rd_en_o,
  output logic [ADDR_WIDTH:0]   ub_rd_addr_o,
  output logic [ADDR_WIDTH:0]   ub_rd_count_o,
  input  logic [DATA_WIDTH-1:0] ub_rd_data_i,
  input  logic                  ub_rd_valid_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   addr_q, addr_d;
  logic [ADDR_WIDTH+1:0] remaining_q, remaining_d;
  logic [ADDR_WIDTH:0]   expected_q, expected_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]      occ_q;
  logic [DATA_WIDTH:0]   head;

  logic [ADDR_WIDTH:0]   blen;
  logic [ADDR_WIDTH+1:0] free_slots;
  logic                  issue, push, pop, push_last, flush, timeout;

  always_comb begin
    if (remaining_q > (ADDR_WIDTH+2)'(BURST_MAX)) blen = (ADDR_WIDTH+1)'(BURST_MAX);
    else                                          blen = remaining_q[ADDR_WIDTH:0];
  end

  // A burst goes out only when every one of its beats already has a FIFO slot.
  assign free_slots = (ADDR_WIDTH+2)'(FIFO_DEPTH) - (ADDR_WIDTH+2)'(occ_q);
  assign issue      = (state_q == S_ISSUE) && (free_slots >= {1'b0, blen});
  assign push       = ub_rd_valid_i && (state_q == S_WAIT);
  assign pop        = out_valid_o && out_ready_i;
  assign push_last  = (remaining_q == '0) && (expected_q == (ADDR_WIDTH+1)'(1));

`ifdef UB_RD_TIMEOUT_EN
  logic [7:0] wdog_q;

  assign timeout = (state_q == S_WAIT) && !ub_rd_valid_i && (wdog_q == 8'd63);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      wdog_q <= '0;
    else if ((state_q != S_WAIT) || ub_rd_valid_i)   wdog_q <= '0;
    else                                             wdog_q <= wdog_q + 8'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    expected_d  = expected_q;
    err_d       = err_q;
    done_d      = 1'b0;
    flush       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          err_d = 1'b0;
          if (cmd_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = cmd_addr_i;
            remaining_d = cmd_len_i;
            state_d     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (issue) begin
          addr_d      = addr_q + blen;
          remaining_d = remaining_q - {1'b0, blen};
          expected_d  = blen;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (timeout) begin
          err_d   = 1'b1;
          flush   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (push) begin
          expected_d = expected_q - (ADDR_WIDTH+1)'(1);
          if (expected_q == (ADDR_WIDTH+1)'(1))
            state_d = (remaining_q != '0) ? S_ISSUE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && out_last_o) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Stray beats are dropped; flag them even if a new command is accepted alongside.
    if (ub_rd_valid_i && (state_q != S_WAIT)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      expected_q  <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      expected_q  <= expected_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_last, ub_rd_data_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign out_valid_o   = (occ_q != '0);
  assign out_data_o    = out_valid_o ? head[DATA_WIDTH-1:0] : '0;
  assign out_last_o    = out_valid_o & head[DATA_WIDTH];
  assign cmd_ready_o   = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign ub_rd_en_o    = issue;
  assign ub_rd_addr_o  = issue ? addr_q : '0;
  assign ub_rd_count_o = issue ? blen : '0;

endmodule

// File: tb/tb_ub_read_streamer.sv
// tb/tb_ub_read_streamer.sv - randomized scoreboard bench for ub_read_streamer
`timescale 1ns/1ps
module tb_ub_read_streamer;
  localparam int DW = 256;
  localparam int AW = 7;
  localparam int FD = 8;
  localparam int BM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready;
  logic [AW:0]   cmd_addr;
  logic [AW+1:0] cmd_len;
  logic          ub_rd_en;
  logic [AW:0]   ub_rd_addr, ub_rd_count;
  logic [DW-1:0] ub_rd_data;
  logic          ub_rd_valid;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          out_last, busy, done, err;

  ub_read_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD), .BURST_MAX(BM)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .ub_rd_en_o(ub_rd_en), .ub_rd_addr_o(ub_rd_addr), .ub_rd_count_o(ub_rd_count),
    .ub_rd_data_i(ub_rd_data), .ub_rd_valid_i(ub_rd_valid),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] mem [256];
  logic [DW:0]   exp_q [$];
  int            bq_addr [$];
  int            bq_cnt [$];

  int bursts_seen = 0;
  int beats_driven = 0;
  int inject_cnt = 0;
  int inject_done = 0;
  int rdy_mode = 0;
  int p_addr = 0, p_cnt = 0, p_dly = 0;
  bit prev_stall = 1'b0;
  logic [DW:0] prev_head = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic check_data(input string name, input logic [DW:0] act, input logic [DW:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: split into bursts of at most BM, addresses wrap modulo 256.
  task automatic push_model(input int a, input int l);
    int r = l;
    int p = a;
    int b;
    while (r > 0) begin
      b = (r > BM) ? BM : r;
      bq_addr.push_back(p);
      bq_cnt.push_back(b);
      p = (p + b) % 256;
      r -= b;
    end
    for (int i = 0; i < l; i++)
      exp_q.push_back({(i == l - 1) ? 1'b1 : 1'b0, mem[(a + i) % 256]});
  endtask

  // Unified buffer model: first beat two cycles after ub_rd_en, then back to back.
  initial begin
    ub_rd_valid = 1'b0;
    ub_rd_data  = '0;
    forever begin
      @(negedge clk);
      ub_rd_valid = 1'b0;
      if (!rst_n) begin
        p_cnt = 0;
        inject_done = inject_cnt;
      end else begin
        if (p_cnt > 0) begin
          if (p_dly > 0) p_dly--;
          else begin
            ub_rd_valid = 1'b1;
            ub_rd_data  = mem[p_addr];
            p_addr = (p_addr + 1) % 256;
            p_cnt--;
            beats_driven++;
          end
        end else if (inject_cnt != inject_done) begin
          ub_rd_valid = 1'b1;
          ub_rd_data  = {8{$urandom}};
          inject_done++;
        end
        if (ub_rd_en) begin
          bursts_seen++;
          if (bq_addr.size() == 0) check("unexpected burst", 1, 0);
          else begin
            check("burst addr", ub_rd_addr, bq_addr.pop_front());
            check("burst count", ub_rd_count, bq_cnt.pop_front());
          end
          p_addr = ub_rd_addr;
          p_cnt  = ub_rd_count;
          p_dly  = 1;
        end
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Output monitor: pops the scoreboard on every accepted beat.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) prev_stall = 1'b0;
      else begin
        if (prev_stall) begin
          check("stall valid hold", out_valid, 1);
          check_data("stall data hold", {out_last, out_data}, prev_head);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("unexpected beat", 1, 0);
          else check_data("beat", {out_last, out_data}, exp_q.pop_front());
        end
        prev_stall = out_valid && !out_ready;
        prev_head  = {out_last, out_data};
      end
    end
  end

  task automatic start_cmd(input int a, input int l);
    @(posedge clk);
    #1;
    check("cmd_ready before cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = a[AW:0];
    cmd_len   = l[AW+1:0];
    push_model(a, l);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input bit lat);
    int n = 0;
    int first = -1;
    @(negedge clk);
    while (!done && n < 3000) begin
      if (out_valid && first < 0) first = n;
      @(negedge clk);
      n++;
    end
    check("done seen", done, 1);
    if (lat) check("first out latency", first, 3);
    check("cmd_ready with done", cmd_ready, 1);
    check("scoreboard drained", exp_q.size(), 0);
    check("bursts drained", bq_addr.size(), 0);
    check("err clear", err, 0);
    @(negedge clk);
    check("done one cycle", done, 0);
    if (n >= 3000) begin
      rst_n = 1'b0;
      exp_q.delete();
      bq_addr.delete();
      bq_cnt.delete();
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  task automatic run_cmd(input int a, input int l, input bit lat);
    start_cmd(a, l);
    wait_done(lat);
  endtask

  initial begin
    #2000000;
    $display("FAIL global timeout: vectors %0d, miscompares %0d", vectors, miscompares);
    $fatal(1, "timeout");
  end

  initial begin
    int b0, d0, n, a, l;
    for (int i = 0; i < 256; i++) mem[i] = {8{$urandom}};
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;

    repeat (3) @(negedge clk);
    check("rst cmd_ready", cmd_ready, 1);
    check("rst ub_rd_en", ub_rd_en, 0);
    check("rst ub_rd_count", ub_rd_count, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_last", out_last, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    rdy_mode = 1;
    run_cmd(8'h10, 10, 1'b1);
    run_cmd(8'hFE, 4, 1'b0);
    run_cmd(8'hFD, 6, 1'b0);
    run_cmd(8'h33, 0, 1'b0);

    // FIFO credit stall with downstream held off
    rdy_mode = 0;
    b0 = bursts_seen;
    d0 = beats_driven;
    start_cmd(8'h20, 16);
    repeat (60) @(negedge clk);
    check("stall bursts", bursts_seen - b0, 2);
    check("stall beats", beats_driven - d0, 8);
    check("stall busy", busy, 1);
    check("stall out_valid", out_valid, 1);
    rdy_mode = 1;
    wait_done(1'b0);

    // Stray return beat while idle
    @(posedge clk);
    #1 inject_cnt++;
    repeat (3) @(negedge clk);
    check("err after stray beat", err, 1);
    check("fifo untouched", out_valid, 0);
    check("idle after stray", cmd_ready, 1);
    run_cmd(8'h80, 5, 1'b0);

    // Asynchronous reset in the middle of WAIT
    b0 = bursts_seen;
    start_cmd(8'h40, 8);
    n = 0;
    while (bursts_seen == b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("burst before reset", bursts_seen - b0, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    bq_addr.delete();
    bq_cnt.delete();
    @(negedge clk);
    check("midreset cmd_ready", cmd_ready, 1);
    check("midreset ub_rd_en", ub_rd_en, 0);
    check("midreset out_valid", out_valid, 0);
    check("midreset busy", busy, 0);
    check("midreset err", err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    rdy_mode = 2;
    for (int k = 0; k < 25; k++) begin
      a = $urandom_range(0, 255);
      l = $urandom_range(0, 40);
      run_cmd(a, l, 1'b0);
    end
    run_cmd(8'hC0, 256, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
